truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Self-checking vector sequencer for small combinational gates (Nand, And, Or, Xor, Mux, ...).
- On start, drives every input combination 0..2^N_IN-1 onto the gate under test, waits a settle time, and samples the gate's output.
- Compares each sample against a parameterised expected truth table, then reports pass/fail, error count and first failing vector.
- Runs on the FPGA as a hardware stand-in for the simulation table dumps; sits between the board start button/LEDs and the combinational gate.

Parameters:
- N_IN, 2, number of gate inputs (1..4).
- EXPECTED, 4'b0111 (Nand), 2^N_IN-bit expected output table; bit k = expected out when dut_in == k (MSB of dut_in = first gate input, e.g. a).
- SETTLE, 1, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- dut_in  output  N_IN  registered vector driven to the gate inputs.
- dut_out  input  1  gate output being checked.
- busy  output  1  high from the start-accepting edge until DONE is left.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 when last sweep had zero mismatches; held until next start.
- err_count  output  N_IN+1  number of mismatching vectors in last sweep (saturates at 2^N_IN, which is the natural maximum).
- fail_valid  output  1  at least one mismatch recorded in the current/last sweep.
- first_fail_idx  output  N_IN  index of the first mismatching vector; valid only when fail_valid=1.

Behaviour:
- Reset (synchronous, overrides everything, including mid-sweep):
  - State to IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_idx=0, internal idx=0, settle counter=0.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE, on start=1 at an edge:
  - Go to APPLY.
  - idx=0, dut_in=0, cnt=0.
  - err_count=0, fail_valid=0, first_fail_idx=0, pass=0.
  - busy rises.
- IDLE, start=0: stay; all result outputs hold.
- APPLY:
  - dut_in holds idx.
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to CHECK.
  - Net effect: the vector is held SETTLE full cycles before the compare edge.
- CHECK, single cycle; on its exit edge dut_out is compared with EXPECTED[idx]:
  - On mismatch: err_count+1. If fail_valid was 0, first_fail_idx=idx and fail_valid=1.
  - If idx == 2^N_IN-1, go to DONE.
  - Otherwise idx+1, dut_in=idx+1, cnt=0, go to APPLY.
  - Same-edge updates (err_count, fail_valid, first_fail_idx) occur together; no combinational path from dut_out to any output.
- DONE, exactly one cycle:
  - done=1, busy=1.
  - pass=(err_count==0), registered on entry.
  - Then go to IDLE; busy=0, done=0, dut_in keeps last vector.
- Latency:
  - Each vector takes SETTLE+1 cycles.
  - done is high in the cycle starting 2^N_IN*(SETTLE+1) edges after the start-accepting edge.
  - Defaults: done high after edge 8, busy high for 9 cycles.
- start while busy (APPLY/CHECK/DONE) is ignored; no restart and no queueing.
- start held high continuously: a new sweep begins on the edge after DONE (from IDLE), and results are cleared then.
- idx wraps never: the sweep terminates at 2^N_IN-1.
- The index counter is N_IN+1 bits or has explicit end compare, so N_IN=4 does not overflow.
- dut_out X/Z during settle is irrelevant; only the compare edge samples it.

Test Plan:
- Defaults, dut_out = ~(dut_in[1]&dut_in[0]) (correct Nand), start pulse at edge 0:
  - dut_in steps 0,1,2,3, each held 2 cycles.
  - done high after edge 8.
  - pass=1, err_count=0, fail_valid=0.
- Defaults, gate replaced by And:
  - All 4 vectors mismatch.
  - err_count=4, fail_valid=1, first_fail_idx=0, pass=0.
- Defaults, dut_out stuck at 1:
  - Only vector 3 mismatches.
  - err_count=1, first_fail_idx=3, pass=0.
- SETTLE=3, correct Nand:
  - Each vector held 3 cycles before compare.
  - done high after edge 16.
  - pass=1.
- start re-pulsed at edge 4 of a sweep:
  - Ignored; done still after edge 8, with a single done pulse.
- reset asserted at edge 5 of a sweep with And gate:
  - Next cycle, all outputs 0 and state IDLE.
  - A subsequent start runs a fresh full sweep with err_count=4.
- N_IN=3, EXPECTED=8'b11001010 (2:1 mux, sel=MSB), correct mux:
  - 8 vectors swept.
  - pass=1, done after edge 16.

Source files
------------

// File: rtl/truth_table_checker.sv
// ============================================================================
//  Module      : truth_table_checker
//  Description : Sweeps every input vector of a small combinational gate,
//                compares each settled output against an expected truth
//                table, and reports pass, error count and first failing index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker #(
    parameter int                     N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 4'b0111,
    parameter int                     SETTLE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = '1;
    localparam logic [N_IN:0]    ERR_MAX  = (N_IN+1)'(1 << N_IN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN:0]    err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_APPLY;
                    idx_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            S_APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                // dut_out is only ever observed here, and only into flops.
                if (dut_out != EXPECTED[idx_q]) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = idx_q;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_APPLY;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dut_in         = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// ============================================================================
//  Module      : tb_truth_table_checker
//  Description : Directed self-checking bench for truth_table_checker using
//                three instances (default Nand, SETTLE=3, N_IN=3 mux).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_checker;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    // Instance 0: defaults, gate selectable (0 Nand, 1 And, 2 stuck-at-1)
    logic [1:0] mode0;
    logic       start0;
    logic [1:0] dut_in0;
    logic       dut_out0;
    logic       busy0, done0, pass0, fv0;
    logic [2:0] err0;
    logic [1:0] ffi0;

    // Instance 1: SETTLE=3, Nand
    logic       start1;
    logic [1:0] dut_in1;
    logic       dut_out1;
    logic       busy1, done1, pass1, fv1;
    logic [2:0] err1;
    logic [1:0] ffi1;

    // Instance 2: N_IN=3, 2:1 mux with sel = dut_in[2]
    logic       start2;
    logic [2:0] dut_in2;
    logic       dut_out2;
    logic       busy2, done2, pass2, fv2;
    logic [3:0] err2;
    logic [2:0] ffi2;

    assign dut_out0 = (mode0 == 2'd0) ? ~(dut_in0[1] & dut_in0[0]) :
                      (mode0 == 2'd1) ?  (dut_in0[1] & dut_in0[0]) : 1'b1;
    assign dut_out1 = ~(dut_in1[1] & dut_in1[0]);
    assign dut_out2 = dut_in2[2] ? dut_in2[1] : dut_in2[0];

    truth_table_checker u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .dut_in(dut_in0),
        .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .first_fail_idx(ffi0)
    );

    truth_table_checker #(.N_IN(2), .EXPECTED(4'b0111), .SETTLE(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .dut_in(dut_in1),
        .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .first_fail_idx(ffi1)
    );

    truth_table_checker #(.N_IN(3), .EXPECTED(8'b11001010), .SETTLE(1)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .dut_in(dut_in2),
        .dut_out(dut_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .first_fail_idx(ffi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({dut_in0, busy0, done0, pass0, err0, fv0, ffi0} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {dut_in0, busy0, done0, pass0, err0, fv0, ffi0});
        end
        total++;
        if ({busy1, done1, pass1, err1, busy2, done2, pass2, err2} !== 13'd0) begin
            bad++;
            $display("FAIL reset_other_instances got=%b want=0", {busy1, done1, pass1, err1, busy2, done2, pass2, err2});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_nand;
        mode0  = 2'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1 || dut_in0 !== 2'd0) begin
            bad++;
            $display("FAIL nand_accept busy=%b dut_in=%0d want busy=1 dut_in=0", busy0, dut_in0);
        end
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (e <= 7) begin
                total++;
                if (dut_in0 !== 2'(e / 2) || done0 !== 1'b0 || busy0 !== 1'b1) begin
                    bad++;
                    $display("FAIL nand_step e=%0d dut_in=%0d done=%b busy=%b want %0d 0 1", e, dut_in0, done0, busy0, e / 2);
                end
            end else if (e == 8) begin
                total++;
                if ({done0, busy0, pass0, err0, fv0} !== {1'b1, 1'b1, 1'b1, 3'd0, 1'b0}) begin
                    bad++;
                    $display("FAIL nand_done got done=%b busy=%b pass=%b err=%0d fv=%b want 1 1 1 0 0", done0, busy0, pass0, err0, fv0);
                end
            end else begin
                total++;
                if ({done0, busy0, pass0, dut_in0} !== {1'b0, 1'b0, 1'b1, 2'd3}) begin
                    bad++;
                    $display("FAIL nand_after_done got done=%b busy=%b pass=%b dut_in=%0d want 0 0 1 3", done0, busy0, pass0, dut_in0);
                end
            end
        end
    endtask

    task automatic test_and_gate;
        mode0  = 2'd1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        total++;
        if ({done0, pass0, err0, fv0, ffi0} !== {1'b1, 1'b0, 3'd4, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL and_result got done=%b pass=%b err=%0d fv=%b ffi=%0d want 1 0 4 1 0", done0, pass0, err0, fv0, ffi0);
        end
        tick();
    endtask

    task automatic test_stuck_one;
        mode0  = 2'd2;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        total++;
        if ({done0, pass0, err0, fv0, ffi0} !== {1'b1, 1'b0, 3'd1, 1'b1, 2'd3}) begin
            bad++;
            $display("FAIL stuck1_result got done=%b pass=%b err=%0d fv=%b ffi=%0d want 1 0 1 1 3", done0, pass0, err0, fv0, ffi0);
        end
        tick();
    endtask

    task automatic test_restart_ignored;
        int dones;
        dones  = 0;
        mode0  = 2'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (done0 === 1'b1) dones++;
            if (e == 8) begin
                total++;
                if (done0 !== 1'b1) begin
                    bad++;
                    $display("FAIL restart_done_edge8 got=%b want=1", done0);
                end
            end
            if (e == 3) start0 = 1'b1;
            if (e == 4) start0 = 1'b0;
        end
        total++;
        if (dones != 1 || pass0 !== 1'b1) begin
            bad++;
            $display("FAIL restart_single_done got dones=%0d pass=%b want 1 1", dones, pass0);
        end
    endtask

    task automatic test_reset_mid_sweep;
        mode0  = 2'd1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({dut_in0, busy0, done0, pass0, err0, fv0, ffi0} !== 11'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=0", {dut_in0, busy0, done0, pass0, err0, fv0, ffi0});
        end
        tick();
        total++;
        if (busy0 !== 1'b0 || dut_in0 !== 2'd0) begin
            bad++;
            $display("FAIL midreset_idle busy=%b dut_in=%0d want 0 0", busy0, dut_in0);
        end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (8) tick();
        total++;
        if ({done0, err0, fv0, ffi0, pass0} !== {1'b1, 3'd4, 1'b1, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_rerun got done=%b err=%0d fv=%b ffi=%0d pass=%b want 1 4 1 0 0", done0, err0, fv0, ffi0, pass0);
        end
        tick();
    endtask

    task automatic test_held_start;
        mode0  = 2'd2;
        start0 = 1'b1;
        tick();
        repeat (8) tick();
        total++;
        if (done0 !== 1'b1 || err0 !== 3'd1) begin
            bad++;
            $display("FAIL held_first_done done=%b err=%0d want 1 1", done0, err0);
        end
        tick();
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 3'd1) begin
            bad++;
            $display("FAIL held_idle_gap busy=%b done=%b err=%0d want 0 0 1", busy0, done0, err0);
        end
        mode0 = 2'd0;
        tick();
        total++;
        if (busy0 !== 1'b1 || err0 !== 3'd0 || fv0 !== 1'b0 || pass0 !== 1'b0) begin
            bad++;
            $display("FAIL held_restart busy=%b err=%0d fv=%b pass=%b want 1 0 0 0", busy0, err0, fv0, pass0);
        end
        start0 = 1'b0;
        repeat (8) tick();
        total++;
        if (done0 !== 1'b1 || pass0 !== 1'b1) begin
            bad++;
            $display("FAIL held_second_result done=%b pass=%b want 1 1", done0, pass0);
        end
        tick();
    endtask

    task automatic test_settle3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e <= 15) begin
                total++;
                if (dut_in1 !== 2'(e / 4) || done1 !== 1'b0) begin
                    bad++;
                    $display("FAIL settle3_step e=%0d dut_in=%0d done=%b want %0d 0", e, dut_in1, done1, e / 4);
                end
            end else if (e == 16) begin
                total++;
                if (done1 !== 1'b1 || pass1 !== 1'b1 || err1 !== 3'd0) begin
                    bad++;
                    $display("FAIL settle3_done done=%b pass=%b err=%0d want 1 1 0", done1, pass1, err1);
                end
            end else begin
                total++;
                if (done1 !== 1'b0 || busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL settle3_after done=%b busy=%b want 0 0", done1, busy1);
                end
            end
        end
    endtask

    task automatic test_mux3;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e <= 15) begin
                total++;
                if (dut_in2 !== 3'(e / 2) || done2 !== 1'b0) begin
                    bad++;
                    $display("FAIL mux3_step e=%0d dut_in=%0d done=%b want %0d 0", e, dut_in2, done2, e / 2);
                end
            end else begin
                total++;
                if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 4'd0 || fv2 !== 1'b0) begin
                    bad++;
                    $display("FAIL mux3_done done=%b pass=%b err=%0d fv=%b want 1 1 0 0", done2, pass2, err2, fv2);
                end
            end
        end
        tick();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        mode0  = 2'd0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_nand();
        test_and_gate();
        test_stuck_one();
        test_restart_ignored();
        test_reset_mid_sweep();
        test_held_start();
        test_settle3();
        test_mux3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
